// File: rtl/ds18b20_poll_scheduler.sv
// Periodic measurement sequencer in front of the DS18B20 driver: issues GET_TEMP,
// tracks the READY handshake with timeouts and retries, and publishes alarms.
`timescale 1ns/1ps

module ds18b20_poll_scheduler #(
   parameter int unsigned PERIOD_CYCLES = 50000000,
   parameter int unsigned ACK_TIMEOUT   = 1000,
   parameter int unsigned DONE_TIMEOUT  = 60000000,
   parameter int unsigned MAX_RETRIES   = 3
) (
   input  logic        DS18B20_CLK,
   input  logic        DS18B20_RESET,
   input  logic        SCHED_ENABLE,
   input  logic        SCHED_SINGLE,
   input  logic [7:0]  SCHED_T_HIGH,
   input  logic [7:0]  SCHED_T_LOW,
   input  logic        DRV_READY,
   input  logic        DRV_ERROR,
   input  logic [11:0] DRV_TEMPERATURE,
   output logic        DRV_GET_TEMP,
   output logic [11:0] SCHED_TEMPERATURE,
   output logic        SCHED_VALID,
   output logic        SCHED_ALARM_HIGH,
   output logic        SCHED_ALARM_LOW,
   output logic        SCHED_FAULT,
   output logic        SCHED_BUSY,
   output logic [15:0] SCHED_SAMPLE_COUNT
);

   localparam logic [2:0] ST_IDLE        = 3'd0;
   localparam logic [2:0] ST_REQ         = 3'd1;
   localparam logic [2:0] ST_WAIT_ACK    = 3'd2;
   localparam logic [2:0] ST_WAIT_DONE   = 3'd3;
   localparam logic [2:0] ST_CHECK       = 3'd4;
   localparam logic [2:0] ST_CAPTURE     = 3'd5;
   localparam logic [2:0] ST_FAIL        = 3'd6;
   localparam logic [2:0] ST_WAIT_PERIOD = 3'd7;

   localparam int unsigned TMO_MAX = (ACK_TIMEOUT > DONE_TIMEOUT) ? ACK_TIMEOUT : DONE_TIMEOUT;
   localparam int unsigned TIMER_W = $clog2(PERIOD_CYCLES + 1);
   localparam int unsigned TMO_W   = $clog2(TMO_MAX + 1);
   localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);

   localparam logic [TIMER_W-1:0] PERIOD_LAST = TIMER_W'(PERIOD_CYCLES - 1);
   // The REQ clock plus the FAIL clock close the ACK window, so FAIL is
   // reached exactly ACK_TIMEOUT clocks after the request pulse.
   localparam logic [TMO_W-1:0]   ACK_LAST    = TMO_W'(ACK_TIMEOUT - 2);
   localparam logic [TMO_W-1:0]   DONE_LAST   = TMO_W'(DONE_TIMEOUT - 1);
   localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

   logic [2:0]         state_q, state_d;
   logic [TIMER_W-1:0] timer_q;
   logic [TMO_W-1:0]   tmo_q;
   logic [RETRY_W-1:0] retry_q;
   logic [RETRY_W-1:0] retry_inc;
   logic               single_q;
   logic               new_period;

   logic signed [7:0]  temp_int;
   logic signed [7:0]  t_high;
   logic signed [7:0]  t_low;

   assign retry_inc = retry_q + 1'b1;
   assign temp_int  = DRV_TEMPERATURE[11:4];
   assign t_high    = SCHED_T_HIGH;
   assign t_low     = SCHED_T_LOW;

   // A fresh sample (not a retry) restarts the period measurement.
   assign new_period = (state_q == ST_IDLE || state_q == ST_WAIT_PERIOD) && (state_d == ST_REQ);

   always_comb begin
      // NOTE: next state defaults to the current one so every path assigns it and no latch is inferred.
      state_d = state_q;
      case (state_q)
         ST_IDLE:        if (SCHED_ENABLE || SCHED_SINGLE) state_d = ST_REQ;
         ST_REQ:         state_d = ST_WAIT_ACK;
         ST_WAIT_ACK: begin
            if (!DRV_READY)            state_d = ST_WAIT_DONE;
            else if (tmo_q >= ACK_LAST) state_d = ST_FAIL;
         end
         ST_WAIT_DONE: begin
            if (DRV_READY)              state_d = ST_CHECK;
            else if (tmo_q >= DONE_LAST) state_d = ST_FAIL;
         end
         ST_CHECK:       state_d = DRV_ERROR ? ST_FAIL : ST_CAPTURE;
         ST_CAPTURE:     state_d = ST_WAIT_PERIOD;
         ST_FAIL:        state_d = (retry_inc < RETRY_LIMIT) ? ST_REQ : ST_WAIT_PERIOD;
         ST_WAIT_PERIOD: begin
            if (single_q || !SCHED_ENABLE) state_d = ST_IDLE;
            else if (timer_q >= PERIOD_LAST) state_d = ST_REQ;
         end
         default:        state_d = ST_IDLE;
      endcase
   end

   // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge DS18B20_CLK or posedge DS18B20_RESET) begin
      if (DS18B20_RESET) begin
         state_q            <= ST_IDLE;
         timer_q            <= '0;
         tmo_q              <= '0;
         retry_q            <= '0;
         single_q           <= 1'b0;
         DRV_GET_TEMP       <= 1'b0;
         SCHED_TEMPERATURE  <= '0;
         SCHED_VALID        <= 1'b0;
         SCHED_ALARM_HIGH   <= 1'b0;
         SCHED_ALARM_LOW    <= 1'b0;
         SCHED_FAULT        <= 1'b0;
         SCHED_BUSY         <= 1'b0;
         SCHED_SAMPLE_COUNT <= '0;
      end else begin
         state_q      <= state_d;
         // Outputs decode the next state so they are registered yet aligned with it.
         DRV_GET_TEMP <= (state_d == ST_REQ);
         SCHED_VALID  <= (state_d == ST_CAPTURE);
         SCHED_BUSY   <= !(state_d == ST_IDLE || state_d == ST_WAIT_PERIOD);

         if (state_d != state_q)  tmo_q <= '0;
         else if (tmo_q != '1)    tmo_q <= tmo_q + 1'b1;

         if (new_period)                  timer_q <= '0;
         else if (timer_q != PERIOD_LAST) timer_q <= timer_q + 1'b1;

         if (state_q == ST_IDLE && state_d == ST_REQ)
            single_q <= SCHED_SINGLE && !SCHED_ENABLE;

         if (state_d == ST_CAPTURE) begin
            SCHED_TEMPERATURE  <= DRV_TEMPERATURE;
            SCHED_ALARM_HIGH   <= (temp_int >= t_high);
            SCHED_ALARM_LOW    <= (temp_int <= t_low);
            SCHED_SAMPLE_COUNT <= SCHED_SAMPLE_COUNT + 16'd1;
            retry_q            <= '0;
            SCHED_FAULT        <= 1'b0;
         end

         if (state_q == ST_FAIL) begin
            if (retry_inc < RETRY_LIMIT) begin
               retry_q <= retry_inc;
            end else begin
               retry_q     <= '0;
               SCHED_FAULT <= 1'b1;
            end
         end

         if (state_q == ST_WAIT_PERIOD && state_d == ST_IDLE)
            SCHED_FAULT <= 1'b0;
      end
   end

endmodule
